// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and helpers for the UART receive path.
// The baud divider is rounded to the nearest whole clock count.
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_e;

  localparam int unsigned UART_OVERSAMPLE = 16;

  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    longint unsigned den;
    longint unsigned num;
    den = 64'(baud) * 64'(UART_OVERSAMPLE);
    num = 64'(clk_hz) + (den / 64'd2);
    return 32'(num / den);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: pin synchroniser, 16x tick divider, deframing FSM,
// and a show-ahead byte FIFO with framing-error and overrun pulses.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV  = uart_div(CLK_HZ, BAUD);
  localparam int          CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0]  SMAX = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]  SMID = 4'(OVERSAMPLE / 2 - 1);

  logic [1:0]     sync_q;
  logic           rx_s;
  logic [CW-1:0]  div_q;
  logic           tick;

  uart_rx_state_e state_q, state_d;
  logic [3:0]     scnt_q, scnt_d;
  logic [2:0]     bidx_q, bidx_d;
  logic [7:0]     shreg_q, shreg_d;

  logic           stop_pt;
  logic           push;
  logic           frame_err_d, frame_err_q;
  logic           overrun_d, overrun_q;
  logic           fifo_full;
  logic           fifo_empty;

  // Raw rx is only ever seen through this two-flop synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  assign tick = (div_q == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            scnt_d  = '0;
          end
        end
        START: begin
          if (scnt_q == SMID) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              scnt_d  = '0;
              bidx_d  = '0;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        DATA: begin
          if (scnt_q == SMAX) begin
            shreg_d = {rx_s, shreg_q[7:1]};
            scnt_d  = '0;
            if (bidx_q == 3'd7) state_d = STOP;
            else                bidx_d  = bidx_q + 3'd1;
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        STOP: begin
          if (scnt_q == SMAX) state_d = rx_s ? IDLE : BREAK;
          else                scnt_d  = scnt_q + 4'd1;
        end
        BREAK: begin
          // Hold here while the line stays low so a stuck-low pin cannot start frames.
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    stop_pt     = tick && (state_q == STOP) && (scnt_q == SMAX);
    push        = stop_pt && rx_s;
    frame_err_d = stop_pt && !rx_s;
    overrun_d   = push && fifo_full && !rd_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rd_valid  = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (int'(FIFO_DEPTH))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shreg_q),
    .full  (fifo_full),
    .pop   (rd_ready),
    .rdata (rd_data),
    .empty (fifo_empty)
  );

endmodule
